fifo_drain_accum: RTL

Downstream consumer for the one-entry FIFO stage: drains its `out_first`/`out_deq` method pair, accumulates a programmed number of 32-bit words into a running sum, then delivers the sum to the next stage through an `enq` method. It converts a word stream into one result per burst. It sits between the FIFO and the indication/response path.

---
 rtl/fifo_drain_accum.sv | 79 +++++++
 1 files changed

// File: rtl/fifo_drain_accum.sv
// Drains a word stream from an upstream FIFO, sums a programmed number of words, and
// enqueues one 32-bit result downstream per burst. Define FIFO_DRAIN_ACCUM_SAT_EN to saturate the sum.
module fifo_drain_accum #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   start__ENA,
  input  logic [COUNT_WIDTH-1:0] start_count,
  output logic                   start__RDY,
  input  logic [31:0]            in_first,
  input  logic                   in_first__RDY,
  input  logic                   in_deq__RDY,
  output logic                   in_deq__ENA,
  output logic [31:0]            out_enq_v,
  input  logic                   out_enq__RDY,
  output logic                   out_enq__ENA,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t                 state;
  logic [31:0]            sum;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [31:0]            sum_next;

  assign start__RDY   = (state == IDLE);
  assign busy         = (state != IDLE);
  assign in_deq__ENA  = (state == ACCUM) && in_first__RDY && in_deq__RDY;
  assign out_enq__ENA = (state == EMIT) && out_enq__RDY;
  assign out_enq_v    = sum;

`ifdef FIFO_DRAIN_ACCUM_SAT_EN
  // A carry out of bit 31 pins the sum at all-ones; adding to all-ones keeps it there.
  logic [32:0] sum_wide;
  assign sum_wide = {1'b0, sum} + {1'b0, in_first};
  assign sum_next = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
`else
  assign sum_next = sum + in_first;
`endif

  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values; blocking here would create ordering-dependent simulation.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      sum       <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start__ENA) begin
            sum <= '0;
            if (start_count == '0) begin
              state <= EMIT;
            end else begin
              remaining <= start_count;
              state     <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_deq__ENA) begin
            sum       <= sum_next;
            remaining <= remaining - 1'b1;
            // Exit at one so a full-scale count never wraps the counter.
            if (remaining == COUNT_WIDTH'(1)) state <= EMIT;
          end
        end
        EMIT: begin
          if (out_enq__ENA) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
